// File: rtl/hamming_encoder_74_tx.sv
// Hamming(7,4) serial transmitter: one nibble per 8-slot frame, b0..b6 LSB first, then a gap slot.
// Gap slot is 0, or the even overall parity of the codeword when HAMMING_TX_SECDED_EN is defined.
module hamming_encoder_74_tx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       encode_out,
  output logic       frame_start,
  output logic       busy,
  output logic [6:0] codeword_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [2:0] LAST_CODE_SLOT = 3'd6;
  localparam logic [2:0] GAP_SLOT       = 3'd7;

  logic [1:0] state_q, state_d;
  logic [2:0] slot_q, slot_d;
  logic       hold_vld_q, hold_vld_d;
  logic [3:0] hold_dat_q, hold_dat_d;
  logic [6:0] shift_q, shift_d;
  logic [6:0] cw_q, cw_d;
  logic       enc_q, enc_d;
  logic       fs_q, fs_d;

  logic [6:0] hold_cw;
  logic       accept;
  logic       transfer;
  logic       gap_bit;

  function automatic logic [6:0] hamming74(input logic [3:0] d);
    logic [6:0] b;
    b[0] = d[0];
    b[1] = d[1];
    b[2] = d[2];
    b[3] = d[2] ^ d[1] ^ d[0];
    b[4] = d[3];
    b[5] = d[3] ^ d[1] ^ d[0];
    b[6] = d[3] ^ d[2] ^ d[0];
    return b;
  endfunction

`ifdef HAMMING_TX_SECDED_EN
  assign gap_bit = ^cw_q;
`else
  assign gap_bit = 1'b0;
`endif

  assign hold_cw  = hamming74(hold_dat_q);
  assign accept   = data_valid && !hold_vld_q;
  // A held nibble leaves only at a frame boundary: from IDLE, or at the end of the gap slot.
  assign transfer = ena && hold_vld_q &&
                    ((state_q == ST_IDLE) || ((state_q == ST_GAP) && (slot_q == GAP_SLOT)));

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    hold_vld_d = hold_vld_q;
    hold_dat_d = hold_dat_q;
    shift_d    = shift_q;
    cw_d       = cw_q;
    enc_d      = enc_q;
    fs_d       = fs_q;

    if (accept) begin
      hold_vld_d = 1'b1;
      hold_dat_d = data_in;
    end else if (transfer) begin
      hold_vld_d = 1'b0;
    end

    if (ena) begin
      case (state_q)
        ST_IDLE: begin
          if (transfer) begin
            state_d = ST_SEND;
            slot_d  = 3'd0;
            cw_d    = hold_cw;
            enc_d   = hold_cw[0];
            shift_d = {1'b0, hold_cw[6:1]};
            fs_d    = 1'b1;
          end
        end
        ST_SEND: begin
          slot_d = slot_q + 3'd1;
          fs_d   = 1'b0;
          if (slot_q == LAST_CODE_SLOT) begin
            state_d = ST_GAP;
            enc_d   = gap_bit;
          end else begin
            enc_d   = shift_q[0];
            shift_d = {1'b0, shift_q[6:1]};
          end
        end
        ST_GAP: begin
          // Counter wraps 7->0 whether the next frame follows or not.
          slot_d = slot_q + 3'd1;
          if (transfer) begin
            state_d = ST_SEND;
            cw_d    = hold_cw;
            enc_d   = hold_cw[0];
            shift_d = {1'b0, hold_cw[6:1]};
            fs_d    = 1'b1;
          end else begin
            state_d = ST_IDLE;
            cw_d    = 7'd0;
            enc_d   = 1'b0;
            fs_d    = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          slot_d  = 3'd0;
          enc_d   = 1'b0;
          fs_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      slot_q     <= 3'd0;
      hold_vld_q <= 1'b0;
      hold_dat_q <= 4'd0;
      shift_q    <= 7'd0;
      cw_q       <= 7'd0;
      enc_q      <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      hold_vld_q <= hold_vld_d;
      hold_dat_q <= hold_dat_d;
      shift_q    <= shift_d;
      cw_q       <= cw_d;
      enc_q      <= enc_d;
      fs_q       <= fs_d;
    end
  end

  assign data_ready   = !hold_vld_q;
  assign encode_out   = enc_q;
  assign frame_start  = fs_q;
  assign busy         = (state_q != ST_IDLE);
  assign codeword_out = cw_q;

endmodule
